// File: rtl/gcd_pkg.sv
// Shared defaults and FSM encoding for the GCD job dispatcher.
package gcd_pkg;
  localparam int GCD_WIDTH   = 16;
  localparam int GCD_DEPTH   = 4;
  localparam int GCD_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } gcd_state_e;
endpackage

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO: {a,b} entries, combinational head, count/full/empty.
module gcd_pair_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/gcd_job_dispatcher.sv
// Feeds queued operand pairs to GCD_Machine one job at a time and streams results;
// zero operands bypass the engine and a watchdog aborts jobs that never complete.
//
// state | meaning
// IDLE  | no job; pops the FIFO head when one is present
// ISSUE | gcd_go high, waiting for the engine to drop done
// WAIT  | engine running, waiting for done to rise
// EMIT  | result held on res_* until res_ready
module gcd_job_dispatcher import gcd_pkg::*; #(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = GCD_DEPTH,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   gcd_go,
  output logic [WIDTH-1:0]       gcd_in1,
  output logic [WIDTH-1:0]       gcd_in2,
  input  logic [WIDTH-1:0]       gcd_out,
  input  logic                   gcd_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_a,
  output logic [WIDTH-1:0]       res_b,
  output logic [WIDTH-1:0]       res_gcd,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int              CW      = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT-1);
  localparam logic [CW-1:0]   WD_MAX  = CW'(TIMEOUT);

  gcd_state_e         state, state_nxt;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a, head_b;
  logic               head_zero;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic               cap_done, cap_to;
  logic               timeout;
  logic [CW-1:0]      wd_cnt;
  logic [WIDTH-1:0]   op_a, op_b;

  assign in_ready  = ~fifo_full;
  assign push      = in_valid & in_ready;
  assign head_a    = head[2*WIDTH-1:WIDTH];
  assign head_b    = head[WIDTH-1:0];
  assign head_zero = (head_a == '0) || (head_b == '0);

  gcd_pair_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Abort on the edge that would make the job's TIMEOUT-th cycle its last.
  assign timeout = ((state == ST_ISSUE) || (state == ST_WAIT)) && (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cap_done  = 1'b0;
    cap_to    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_zero ? ST_EMIT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (timeout) begin
          cap_to    = 1'b1;
          state_nxt = ST_EMIT;
        end else if (!gcd_done) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timeout) begin
          cap_to    = 1'b1;
          state_nxt = ST_EMIT;
        end else if (gcd_done) begin
          cap_done  = 1'b1;
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = head_zero ? ST_EMIT : ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      res_gcd <= '0;
      res_err <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        op_a    <= head_a;
        op_b    <= head_b;
        res_gcd <= head_a | head_b;
        res_err <= 1'b0;
        wd_cnt  <= '0;
      end else if (((state == ST_ISSUE) || (state == ST_WAIT)) && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (cap_to) begin
        res_gcd <= '0;
        res_err <= 1'b1;
      end else if (cap_done) begin
        res_gcd <= gcd_out;
        res_err <= 1'b0;
      end
    end
  end

  assign gcd_go    = (state == ST_ISSUE);
  assign res_valid = (state == ST_EMIT);
  assign busy      = (state != ST_IDLE);
  assign gcd_in1   = op_a;
  assign gcd_in2   = op_b;
  assign res_a     = op_a;
  assign res_b     = op_b;
endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Directed + randomized bench: behavioural GCD engine model and an in-order result scoreboard.
module tb_gcd_job_dispatcher;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid, in_ready;
  logic [W-1:0]     in_a, in_b;
  logic             gcd_go;
  logic [W-1:0]     gcd_in1, gcd_in2, gcd_out;
  logic             gcd_done;
  logic             res_valid, res_ready;
  logic [W-1:0]     res_a, res_b, res_gcd;
  logic             res_err, busy;
  logic [$clog2(D):0] fifo_count;

  int checks = 0;
  int errors = 0;
  int mode = 0;        // engine: 0 normal, 1 done stuck high, 2 hangs after starting
  int acc_cnt = 0;
  int go_cycles = 0;
  int max_count = 0;
  logic [W-1:0] last_res = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         e;
  } exp_t;
  exp_t sb[$];

  gcd_job_dispatcher #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .gcd_go(gcd_go), .gcd_in1(gcd_in1), .gcd_in2(gcd_in2),
    .gcd_out(gcd_out), .gcd_done(gcd_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .res_gcd(res_gcd), .res_err(res_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [W-1:0] rand_nz();
    return W'($urandom_range(1, 65535));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Engine model: idle with done=1, drops done when it takes GO, raises it with the result.
  logic         eng_busy;
  int           eng_dly;
  logic [W-1:0] eng_x, eng_y;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcd_done <= 1'b1;
      gcd_out  <= '0;
      eng_busy <= 1'b0;
      eng_dly  <= 0;
      eng_x    <= '0;
      eng_y    <= '0;
    end else if (mode != 1) begin
      if (!eng_busy && gcd_go) begin
        eng_busy <= 1'b1;
        gcd_done <= 1'b0;
        eng_dly  <= int'($urandom_range(1, 6));
        eng_x    <= gcd_in1;
        eng_y    <= gcd_in2;
      end else if (eng_busy && mode == 0) begin
        if (eng_dly == 0) begin
          gcd_out  <= ref_gcd(eng_x, eng_y);
          gcd_done <= 1'b1;
          eng_busy <= 1'b0;
        end else begin
          eng_dly <= eng_dly - 1;
        end
      end
    end
  end

  // Monitor: records accepted pairs with their expected result and checks every delivered result.
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (rst) begin
      if (gcd_go) go_cycles++;
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (res_valid && res_ready) begin
        last_res = res_gcd;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_result: observed gcd %0d with no job outstanding", res_gcd);
        end else begin
          e = sb.pop_front();
          check("res_a", res_a, e.a);
          check("res_b", res_b, e.b);
          check("res_gcd", res_gcd, e.g);
          check("res_err", res_err, e.e);
        end
      end
      if (in_valid && in_ready) begin
        n.a = in_a;
        n.b = in_b;
        if (in_a == 0 || in_b == 0 || mode == 0) begin
          n.g = ref_gcd(in_a, in_b);
          n.e = 1'b0;
        end else begin
          n.g = '0;
          n.e = 1'b1;
        end
        sb.push_back(n);
        acc_cnt++;
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n0 = acc_cnt;
    int k = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #2;
      k++;
    end while (acc_cnt == n0 && k < 500);
    in_valid = 1'b0;
    if (acc_cnt == n0) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: pair (%0d,%0d) not accepted, observed count %0d", a, b, acc_cnt);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || fifo_count != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(n < 1000), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_gcd_go", gcd_go, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_res_gcd", res_gcd, 0);
    check("rst_res_err", res_err, 0);
    check("rst_res_a", res_a, 0);
    check("rst_gcd_in1", gcd_in1, 0);
    @(posedge clk); #2;
    rst = 1'b1;

    // single job through the engine
    res_ready = 1'b1;
    go_cycles = 0;
    push(16'd10, 16'd5);
    wait_drain("single");
    check("single_go_seen", 32'(go_cycles > 0), 1);
    check("single_gcd", last_res, 5);

    // back-to-back queue
    max_count = 0;
    push(16'd24, 16'd11);
    push(16'd48, 16'd6);
    push(16'd10, 16'd5);
    wait_drain("b2b");
    check("b2b_peak_ge2", 32'(max_count >= 2), 1);
    check("b2b_count_end", fifo_count, 0);

    // zero-operand bypass, one-cycle latency, engine untouched
    go_cycles = 0;
    push(16'd0, 16'd9);
    @(negedge clk);
    check("byp1_rv_early", res_valid, 0);
    @(negedge clk);
    check("byp1_rv", res_valid, 1);
    check("byp1_gcd", res_gcd, 9);
    wait_drain("byp1");
    push(16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check("byp2_rv", res_valid, 1);
    check("byp2_gcd", res_gcd, 0);
    wait_drain("byp2");
    check("byp_no_go", go_cycles, 0);

    // backpressure: one job parked in EMIT, FIFO filled, extra pair held off
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(rand_nz(), rand_nz());
    n0 = acc_cnt;
    in_a = rand_nz();
    in_b = rand_nz();
    in_valid = 1'b1;
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("bp_res_valid", res_valid, 1);
    check("bp_fifo_full", fifo_count, D);
    check("bp_in_ready", in_ready, 0);
    check("bp_held_off", acc_cnt, n0);
    @(posedge clk); #2;
    res_ready = 1'b1;
    k = 0;
    while (acc_cnt == n0 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc_cnt, n0 + 1);
    wait_drain("bp");

    // watchdog with done stuck high
    mode = 1;
    go_cycles = 0;
    push(16'd8, 16'd4);
    k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wd_go_cycles", go_cycles, TO);
    check("wd_gcd_go", gcd_go, 0);
    check("wd_res_err", res_err, 1);
    check("wd_res_gcd", res_gcd, 0);
    wait_drain("wd");
    mode = 0;

    // random mix including zero operands
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 3) == 0) ? '0 : rand_nz();
      b = ($urandom_range(0, 3) == 0) ? '0 : rand_nz();
      push(a, b);
    end
    wait_drain("rand");

    // reset while a job is in WAIT with two pairs queued
    mode = 2;
    push(16'd14, 16'd21);
    push(16'd9, 16'd6);
    push(16'd7, 16'd7);
    @(posedge clk); #2;
    check("mid_busy", busy, 1);
    check("mid_go_low", gcd_go, 0);
    check("mid_fifo", fifo_count, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_go", gcd_go, 0);
    check("mid_rst_rv", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fifo", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    mode = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    push(16'd12, 16'd18);
    wait_drain("post_rst");
    check("post_rst_gcd", last_res, 6);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
